// File: rtl/keypad_digit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_digit_buffer
//  Purpose  : Collects keypad keystrokes into NDIGITS display slots and
//             presents them as a flat bus for the display multiplexer.
//             Two entry modes (positional fill / calculator-style shift),
//             CLEAR / BACKSPACE / ENTER commands, digit range checking and
//             full / entered / rejected status.
//  Optional : define KEYPAD_BUF_WRAP_EN to accept digits while FULL
//             (round-robin overwrite in MODE 0, shift-out in MODE 1).
//             Without it, a digit while FULL is rejected.
//  Ports    :
//     clk          system clock, all updates on rising edge
//     reset        asynchronous, active-high reset
//     key_valid_i  one-cycle keystroke strobe (already synchronous to clk)
//     key_cmd_i    0 = digit key, 1 = command key
//     key_code_i   digit value or command (0 CLEAR, 1 BACKSPACE, 2 ENTER)
//     digits_o     slot i at bits [i*DW +: DW]
//     count_o      number of occupied slots
//     state_o      00 EMPTY, 01 ENTRY, 10 FULL, 11 LOCKED
//     full_o       count_o == NDIGITS
//     entered_o    one-cycle pulse when ENTER is accepted
//     rejected_o   one-cycle pulse when a keystroke is refused
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_digit_buffer #(
   parameter int          NDIGITS  = 4,
   parameter int          DW       = 4,
   parameter int unsigned MAXDIGIT = 9,
   parameter int          MODE     = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             key_valid_i,
   input  logic                             key_cmd_i,
   input  logic [DW-1:0]                    key_code_i,
   output logic [NDIGITS*DW-1:0]            digits_o,
   output logic [$clog2(NDIGITS+1)-1:0]     count_o,
   output logic [1:0]                       state_o,
   output logic                             full_o,
   output logic                             entered_o,
   output logic                             rejected_o
);

   localparam int CW = $clog2(NDIGITS+1);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   localparam logic [CW-1:0] CNT_FULL  = CW'(NDIGITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(NDIGITS-1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] PTR_LAST  = IW'(NDIGITS-1);
   localparam logic [IW-1:0] PTR_RELOAD = (NDIGITS == 1) ? IW'(0) : IW'(1);

   localparam logic [DW-1:0] CMD_CLEAR = DW'(0);
   localparam logic [DW-1:0] CMD_BKSP  = DW'(1);
   localparam logic [DW-1:0] CMD_ENTER = DW'(2);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'b00,
      ST_ENTRY  = 2'b01,
      ST_FULL   = 2'b10,
      ST_LOCKED = 2'b11
   } state_t;

   typedef logic [NDIGITS-1:0][DW-1:0] slots_t;

   slots_t          digits_q, digits_d;
   logic [CW-1:0]   count_q,  count_d;
   state_t          state_q,  state_d;
   logic [IW-1:0]   wptr_q,   wptr_d;
   logic            entered_q, entered_d;
   logic            rejected_q, rejected_d;

   logic            digit_ok;
   logic [IW-1:0]   wptr_inc;

   assign digit_ok = (32'(key_code_i) <= MAXDIGIT);

   // Write pointer for positional mode. Outside wrap-around use it always
   // equals count modulo NDIGITS; it only diverges while overwriting in FULL.
   assign wptr_inc = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;

   // Insert a new digit: positional write at ptr, or shift-up with the
   // top slot falling off (only reachable when full in wrap mode).
   function automatic slots_t push_digit(input slots_t cur,
                                         input logic [IW-1:0] ptr,
                                         input logic [DW-1:0] code);
      slots_t r;
      r = cur;
      if (MODE == 0) begin
         r[ptr] = code;
      end else begin
         for (int i = NDIGITS-1; i > 0; i--) r[i] = cur[i-1];
         r[0] = code;
      end
      return r;
   endfunction

   // Remove the most recent digit: clear slot idx, or shift everything down.
   function automatic slots_t pop_digit(input slots_t cur,
                                        input logic [IW-1:0] idx);
      slots_t r;
      r = cur;
      if (MODE == 0) begin
         r[idx] = '0;
      end else begin
         for (int i = 0; i < NDIGITS-1; i++) r[i] = cur[i+1];
         r[NDIGITS-1] = '0;
      end
      return r;
   endfunction

   always_comb begin
      digits_d   = digits_q;
      count_d    = count_q;
      state_d    = state_q;
      wptr_d     = wptr_q;
      entered_d  = 1'b0;
      rejected_d = 1'b0;

      if (key_valid_i) begin
         if (!key_cmd_i) begin
            if (!digit_ok) begin
               rejected_d = 1'b1;
            end else begin
               case (state_q)
                  ST_LOCKED: begin
                     // Fresh entry: the frozen value is discarded first.
                     digits_d    = '0;
                     digits_d[0] = key_code_i;
                     count_d     = CNT_ONE;
                     wptr_d      = PTR_RELOAD;
                     state_d     = (NDIGITS == 1) ? ST_FULL : ST_ENTRY;
                  end
                  ST_FULL: begin
`ifdef KEYPAD_BUF_WRAP_EN
                     digits_d = push_digit(digits_q, wptr_q, key_code_i);
                     wptr_d   = wptr_inc;
`else
                     rejected_d = 1'b1;
`endif
                  end
                  default: begin
                     digits_d = push_digit(digits_q, wptr_q, key_code_i);
                     wptr_d   = wptr_inc;
                     count_d  = count_q + 1'b1;
                     state_d  = (count_q == CNT_LAST) ? ST_FULL : ST_ENTRY;
                  end
               endcase
            end
         end else begin
            case (key_code_i)
               CMD_CLEAR: begin
                  digits_d = '0;
                  count_d  = '0;
                  wptr_d   = '0;
                  state_d  = ST_EMPTY;
               end
               CMD_BKSP: begin
                  if (state_q == ST_LOCKED || count_q == '0) begin
                     rejected_d = 1'b1;
                  end else begin
                     digits_d = pop_digit(digits_q, IW'(count_q - 1'b1));
                     count_d  = count_q - 1'b1;
                     wptr_d   = IW'(count_q - 1'b1);
                     state_d  = (count_q == CNT_ONE) ? ST_EMPTY : ST_ENTRY;
                  end
               end
               CMD_ENTER: begin
                  if (state_q == ST_LOCKED || count_q == '0) begin
                     rejected_d = 1'b1;
                  end else begin
                     state_d   = ST_LOCKED;
                     entered_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_EMPTY;
         wptr_q     <= '0;
         entered_q  <= 1'b0;
         rejected_q <= 1'b0;
      end else begin
         digits_q   <= digits_d;
         count_q    <= count_d;
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         entered_q  <= entered_d;
         rejected_q <= rejected_d;
      end
   end

   assign digits_o   = digits_q;
   assign count_o    = count_q;
   assign state_o    = state_q;
   assign full_o     = (count_q == CNT_FULL);
   assign entered_o  = entered_q;
   assign rejected_o = rejected_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_digit_buffer
//  Purpose  : Self-checking bench for keypad_digit_buffer. Three instances
//             share the key inputs: N=4/MODE0, N=4/MODE1, N=1/MODE0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_buffer;

`ifdef KEYPAD_BUF_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic        key_cmd;
   logic [3:0]  key_code;

   logic [15:0] d0, d1;
   logic [3:0]  d2;
   logic [2:0]  c0, c1;
   logic [0:0]  c2;
   logic [1:0]  s0, s1, s2;
   logic        f0, f1, f2, e0, e1, e2, r0, r1, r2;

   always #5 clk = ~clk;

   keypad_digit_buffer #(.NDIGITS(4), .DW(4), .MAXDIGIT(9), .MODE(0)) u0 (
      .clk(clk), .reset(reset), .key_valid_i(key_valid), .key_cmd_i(key_cmd),
      .key_code_i(key_code), .digits_o(d0), .count_o(c0), .state_o(s0),
      .full_o(f0), .entered_o(e0), .rejected_o(r0));

   keypad_digit_buffer #(.NDIGITS(4), .DW(4), .MAXDIGIT(9), .MODE(1)) u1 (
      .clk(clk), .reset(reset), .key_valid_i(key_valid), .key_cmd_i(key_cmd),
      .key_code_i(key_code), .digits_o(d1), .count_o(c1), .state_o(s1),
      .full_o(f1), .entered_o(e1), .rejected_o(r1));

   keypad_digit_buffer #(.NDIGITS(1), .DW(4), .MAXDIGIT(9), .MODE(0)) u2 (
      .clk(clk), .reset(reset), .key_valid_i(key_valid), .key_cmd_i(key_cmd),
      .key_code_i(key_code), .digits_o(d2), .count_o(c2), .state_o(s2),
      .full_o(f2), .entered_o(e2), .rejected_o(r2));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // MODE 0 instances: slot array + count + round-robin pointer.
   // MODE 1 instance : queue of digits, newest first (q1[0] is slot 0).
   int NK[3] = '{4, 4, 1};
   int MK[3] = '{0, 1, 0};
   int slot[3][16];
   int cnt[3];
   int ptr[3];
   bit lk[3];
   bit xe[3];
   bit xr[3];
   int q1[$];

   function automatic int m_count(int k);
      return (MK[k] == 1) ? q1.size() : cnt[k];
   endfunction

   function automatic int m_slot(int k, int i);
      if (MK[k] == 1) return (i < q1.size()) ? q1[i] : 0;
      return slot[k][i];
   endfunction

   task automatic m_clear(int k);
      for (int i = 0; i < 16; i++) slot[k][i] = 0;
      cnt[k] = 0; ptr[k] = 0; lk[k] = 0;
      if (MK[k] == 1) q1.delete();
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_clear(k); xe[k] = 0; xr[k] = 0;
      end
   endtask

   task automatic model_step(int k, bit cmd, int code);
      int n, c;
      n = NK[k]; c = m_count(k);
      xe[k] = 0; xr[k] = 0;
      if (!cmd) begin
         if (code > 9) xr[k] = 1;
         else if (lk[k]) begin
            m_clear(k);
            if (MK[k] == 1) q1.push_front(code);
            else begin slot[k][0] = code; cnt[k] = 1; ptr[k] = 1 % n; end
         end else if (c == n) begin
            if (WRAP) begin
               if (MK[k] == 1) begin q1.push_front(code); void'(q1.pop_back()); end
               else begin slot[k][ptr[k]] = code; ptr[k] = (ptr[k] + 1) % n; end
            end else xr[k] = 1;
         end else begin
            if (MK[k] == 1) q1.push_front(code);
            else begin slot[k][cnt[k]] = code; cnt[k]++; ptr[k] = cnt[k] % n; end
         end
      end else begin
         case (code)
            0: m_clear(k);
            1: if (lk[k] || c == 0) xr[k] = 1;
               else if (MK[k] == 1) void'(q1.pop_front());
               else begin cnt[k]--; slot[k][cnt[k]] = 0; ptr[k] = cnt[k]; end
            2: if (lk[k] || c == 0) xr[k] = 1;
               else begin lk[k] = 1; xe[k] = 1; end
            default: ;
         endcase
      end
   endtask

   task automatic check_inst(int k, logic [63:0] dig, logic [63:0] cn,
                             logic [63:0] st, logic fl, logic en, logic rj);
      logic [63:0] ed;
      int c, es;
      ed = '0;
      for (int i = 0; i < NK[k]; i++) ed |= 64'(m_slot(k, i)) << (4*i);
      c  = m_count(k);
      es = lk[k] ? 3 : (c == 0) ? 0 : (c == NK[k]) ? 2 : 1;
      chk($sformatf("u%0d.digits", k), dig, ed);
      chk($sformatf("u%0d.count", k), cn, 64'(c));
      chk($sformatf("u%0d.state", k), st, 64'(es));
      chk($sformatf("u%0d.full", k), 64'(fl), 64'(c == NK[k]));
      chk($sformatf("u%0d.entered", k), 64'(en), 64'(xe[k]));
      chk($sformatf("u%0d.rejected", k), 64'(rj), 64'(xr[k]));
   endtask

   task automatic check_all();
      check_inst(0, 64'(d0), 64'(c0), 64'(s0), f0, e0, r0);
      check_inst(1, 64'(d1), 64'(c1), 64'(s1), f1, e1, r1);
      check_inst(2, 64'(d2), 64'(c2), 64'(s2), f2, e2, r2);
   endtask

   // One keystroke: drive at negedge, sample 1 ns after the capturing edge.
   task automatic press(bit cmd, logic [3:0] code);
      @(negedge clk);
      key_valid = 1'b1; key_cmd = cmd; key_code = code;
      @(posedge clk); #1;
      key_valid = 1'b0;
      for (int k = 0; k < 3; k++) model_step(k, cmd, int'(code));
      check_all();
   endtask

   task automatic idle();
      @(negedge clk);
      key_valid = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin xe[k] = 0; xr[k] = 0; end
      check_all();
   endtask

   // ---------------- directed vectors for u0 ----------------
   typedef struct {
      bit          v;
      bit          cmd;
      logic [3:0]  code;
      logic [15:0] dig;
      int          cnt;
      logic [1:0]  st;
      bit          fl;
      bit          en;
      bit          rj;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit v, bit cmd, logic [3:0] code, logic [15:0] dig,
                               int cn, logic [1:0] st, bit fl, bit en, bit rj);
      vec_t t;
      t.v = v; t.cmd = cmd; t.code = code; t.dig = dig; t.cnt = cn;
      t.st = st; t.fl = fl; t.en = en; t.rj = rj;
      return t;
   endfunction

   initial begin
      reset = 1'b1; key_valid = 1'b0; key_cmd = 1'b0; key_code = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) reset = 1'b0;

      //                 v cmd code  digits                      cnt st  fl en rj
      tbl.push_back(mk(1, 0, 4'h1, 16'h0001,                    1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h2, 16'h0021,                    2, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h3, 16'h0321,                    3, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h4, 16'h4321,                    4, 2, 1, 0, 0));
      tbl.push_back(mk(1, 1, 4'h2, 16'h4321,                    4, 3, 1, 1, 0));
      tbl.push_back(mk(1, 1, 4'h1, 16'h4321,                    4, 3, 1, 0, 1));
      tbl.push_back(mk(1, 1, 4'h2, 16'h4321,                    4, 3, 1, 0, 1));
      tbl.push_back(mk(1, 0, 4'h6, 16'h0006,                    1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 4'h0, 16'h0000,                    0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'hC, 16'h0000,                    0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 4'h1, 16'h0000,                    0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 4'h2, 16'h0000,                    0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 4'h5, 16'h0000,                    0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 4'h0, 16'h0000,                    0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h1, 16'h0001,                    1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h2, 16'h0021,                    2, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h3, 16'h0321,                    3, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h4, 16'h4321,                    4, 2, 1, 0, 0));
      tbl.push_back(mk(1, 0, 4'h9, WRAP ? 16'h4329 : 16'h4321,  4, 2, 1, 0, !WRAP));
      tbl.push_back(mk(1, 0, 4'h5, WRAP ? 16'h4359 : 16'h4321,  4, 2, 1, 0, !WRAP));
      tbl.push_back(mk(1, 1, 4'h1, WRAP ? 16'h0359 : 16'h0321,  3, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 4'h4, WRAP ? 16'h4359 : 16'h4321,  4, 2, 1, 0, 0));
      tbl.push_back(mk(1, 1, 4'h0, 16'h0000,                    0, 0, 0, 0, 0));

      foreach (tbl[j]) begin
         if (tbl[j].v) press(tbl[j].cmd, tbl[j].code);
         else          idle();
         chk($sformatf("vec%0d.digits", j), 64'(d0), 64'(tbl[j].dig));
         chk($sformatf("vec%0d.count", j), 64'(c0), 64'(tbl[j].cnt));
         chk($sformatf("vec%0d.state", j), 64'(s0), 64'(tbl[j].st));
         chk($sformatf("vec%0d.full", j), 64'(f0), 64'(tbl[j].fl));
         chk($sformatf("vec%0d.entered", j), 64'(e0), 64'(tbl[j].en));
         chk($sformatf("vec%0d.rejected", j), 64'(r0), 64'(tbl[j].rj));
      end

      // Shift mode: 7, 8, BACKSPACE on u1; N=1 corner on u2.
      press(1'b0, 4'h7);
      chk("n1.state_after_7", 64'(s2), 64'd2);
      chk("n1.full_after_7", 64'(f2), 64'd1);
      press(1'b0, 4'h8);
      chk("shift.slot0", 64'(d1[3:0]), 64'h8);
      chk("shift.slot1", 64'(d1[7:4]), 64'h7);
      chk("n1.digit_after_8", 64'(d2), WRAP ? 64'h8 : 64'h7);
      chk("n1.rej_after_8", 64'(r2), 64'(!WRAP));
      press(1'b1, 4'h1);
      chk("shift_bs.slot0", 64'(d1[3:0]), 64'h7);
      chk("shift_bs.slot1", 64'(d1[7:4]), 64'h0);
      chk("shift_bs.count", 64'(c1), 64'd1);
      chk("n1.state_after_bs", 64'(s2), 64'd0);
      press(1'b1, 4'h0);

      // Asynchronous reset mid-entry with a keystroke in flight.
      press(1'b0, 4'h1);
      press(1'b0, 4'h2);
      chk("pre_reset.count", 64'(c0), 64'd2);
      @(negedge clk);
      key_valid = 1'b1; key_cmd = 1'b0; key_code = 4'h3;
      #2 reset = 1'b1;
      #1;
      chk("async_reset.digits", 64'(d0), 64'h0);
      chk("async_reset.count", 64'(c0), 64'd0);
      chk("async_reset.state", 64'(s0), 64'd0);
      chk("async_reset.full", 64'(f0), 64'd0);
      chk("async_reset.pulses", 64'({e0, r0}), 64'd0);
      chk("async_reset.u1_count", 64'(c1), 64'd0);
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("held_reset.digits", 64'(d0), 64'h0);
      @(negedge clk) reset = 1'b0;
      model_reset();
      idle();

      // Randomized keystrokes against the model.
      for (int n = 0; n < 800; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 68)      press(1'b0, 4'($urandom_range(0, 11)));
         else if (r < 80) press(1'b1, 4'h1);
         else if (r < 88) press(1'b1, 4'h2);
         else if (r < 91) press(1'b1, 4'h0);
         else if (r < 94) press(1'b1, 4'($urandom_range(3, 15)));
         else             idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
